// File: rtl/sdram_readback.sv
// ---------------------------------------------------------------------------
// sdram_readback
//
// Read-side counterpart of the ADC-to-SDRAM capture path. A start request
// launches one read-master transfer of NUM_BYTES from the current base
// address. Each 32-bit FIFO word {first,second} is split into two 16-bit
// samples and presented first-then-second on a valid/ready stream towards
// the SPI readout logic. After a fully delivered transfer the base address
// advances by NUM_BYTES and wraps back to BASE_ADDR at ADDR_WRAP. An abort
// drains whatever the master still delivers and returns to idle without a
// done pulse and without moving the base address.
//
// Ports
//   rx_clk_out                   block clock
//   reset_n                      asynchronous active-low reset
//   start                        1-cycle request, honoured only when idle
//   abort                        abandon the running transfer
//   read_control_fixed_location  constant 0 (incrementing addresses)
//   read_control_base            transfer base address
//   read_control_length          constant NUM_BYTES
//   read_control_go              1-cycle launch pulse for the read master
//   read_control_done            master finished all bus reads
//   read_data_available          show-ahead FIFO non-empty
//   read_buffer_data             FIFO head word
//   read_acknowledge             1-cycle pop of the FIFO head
//   sample_out / sample_valid    sample stream towards the consumer
//   sample_ready                 consumer accepts when valid && ready
//   busy                         high whenever not idle
//   done                         1-cycle pulse when a transfer completes
// ---------------------------------------------------------------------------
module sdram_readback #(
    parameter int unsigned NUM_BYTES = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] ADDR_WRAP = 32'h10000
) (
    input  logic        rx_clk_out,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic        read_control_fixed_location,
    output logic [31:0] read_control_base,
    output logic [31:0] read_control_length,
    output logic        read_control_go,
    input  logic        read_control_done,
    input  logic        read_data_available,
    input  logic [31:0] read_buffer_data,
    output logic        read_acknowledge,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] WORDS = 32'(NUM_BYTES / 4);
    localparam logic [32:0] LEN33 = 33'(NUM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_WAIT_DATA,
        S_HI,
        S_LO,
        S_WAIT_DONE,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] base;
    logic [31:0] words_left;
    logic        done_seen;
    logic [31:0] hold;

    logic        go_d;
    logic        ack_d;
    logic        valid_d;
    logic [15:0] sample_d;
    logic        busy_d;
    logic        done_d;

    logic        active;
    logic        accept;
    logic        master_done;
    logic        capture;
    logic [32:0] base_sum;
    logic [31:0] base_next;

    assign read_control_fixed_location = 1'b0;
    assign read_control_length         = 32'(NUM_BYTES);
    assign read_control_base           = base;

    // States in which an abort is honoured.
    assign active      = (state == S_GO) || (state == S_WAIT_DATA) || (state == S_HI) ||
                         (state == S_LO) || (state == S_WAIT_DONE);
    assign accept      = sample_valid && sample_ready;
    assign master_done = done_seen || read_control_done;
    assign capture     = (state == S_WAIT_DATA) && (next_state == S_HI);

    // 33-bit sum so a base near the top of the address space still wraps.
    assign base_sum  = {1'b0, base} + LEN33;
    assign base_next = (base_sum >= {1'b0, ADDR_WRAP}) ? BASE_ADDR : base_sum[31:0];

    // State register, bookkeeping registers and registered outputs.
    always_ff @(posedge rx_clk_out or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            base             <= BASE_ADDR;
            words_left       <= '0;
            done_seen        <= 1'b0;
            read_control_go  <= 1'b0;
            read_acknowledge <= 1'b0;
            sample_valid     <= 1'b0;
            sample_out       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= next_state;
            read_control_go  <= go_d;
            read_acknowledge <= ack_d;
            sample_valid     <= valid_d;
            sample_out       <= sample_d;
            busy             <= busy_d;
            done             <= done_d;

            if (state == S_GO) begin
                words_left <= WORDS;
            end else if ((state == S_LO) && (next_state != S_LO) && (next_state != S_DRAIN)) begin
                words_left <= words_left - 32'd1;
            end

            // An early master done must survive until the last sample leaves.
            if (state == S_GO) begin
                done_seen <= 1'b0;
            end else if ((state != S_IDLE) && read_control_done) begin
                done_seen <= 1'b1;
            end

            if (state == S_DONE) begin
                base <= base_next;
            end
        end
    end

    // Word holding register; only meaningful once captured, so no reset.
    always_ff @(posedge rx_clk_out) begin
        if (capture) begin
            hold <= read_buffer_data;
        end
    end

    // Next-state logic; abort outranks any same-cycle acceptance.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:      if (start) next_state = S_GO;
            S_GO:        next_state = abort ? S_DRAIN : S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (abort)                    next_state = S_DRAIN;
                else if (read_data_available) next_state = S_HI;
            end
            S_HI: begin
                if (abort)       next_state = S_DRAIN;
                else if (accept) next_state = S_LO;
            end
            S_LO: begin
                if (abort)       next_state = S_DRAIN;
                else if (accept) next_state = (words_left == 32'd1) ? S_WAIT_DONE : S_WAIT_DATA;
            end
            S_WAIT_DONE: begin
                if (abort)            next_state = S_DRAIN;
                else if (master_done) next_state = S_DONE;
            end
            S_DONE:      next_state = S_IDLE;
            S_DRAIN:     if (master_done && !read_data_available) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        go_d     = (next_state == S_GO);
        valid_d  = (next_state == S_HI) || (next_state == S_LO);
        busy_d   = (next_state != S_IDLE);
        done_d   = (next_state == S_DONE);
        ack_d    = capture;
        // While draining, an ack takes effect one edge later, so skip the
        // cycle in which the previous pop is still pending.
        if ((state == S_DRAIN) && read_data_available && !read_acknowledge) begin
            ack_d = 1'b1;
        end
        sample_d = sample_out;
        if (capture) begin
            sample_d = read_buffer_data[31:16];
        end else if ((state == S_HI) && (next_state == S_LO)) begin
            sample_d = hold[15:0];
        end
    end

endmodule

// File: tb/tb_sdram_readback.sv
// ---------------------------------------------------------------------------
// tb_sdram_readback
//
// Bench for sdram_readback: a show-ahead FIFO model feeds words, a monitor
// collects accepted samples, and each transfer is compared against the
// expected sample sequence, ack count, done pulses and base address.
// ---------------------------------------------------------------------------
module tb_sdram_readback;

    localparam int NB    = 64;
    localparam int WORDS = NB / 4;

    logic        rx_clk_out = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        read_control_fixed_location;
    logic [31:0] read_control_base;
    logic [31:0] read_control_length;
    logic        read_control_go;
    logic        read_control_done;
    logic        read_data_available = 1'b0;
    logic [31:0] read_buffer_data = '0;
    logic        read_acknowledge;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        busy;
    logic        done;

    always #5 rx_clk_out = ~rx_clk_out;

    sdram_readback #(
        .NUM_BYTES (NB),
        .BASE_ADDR (32'h0),
        .ADDR_WRAP (32'h80)
    ) dut (
        .rx_clk_out                  (rx_clk_out),
        .reset_n                     (reset_n),
        .start                       (start),
        .abort                       (abort),
        .read_control_fixed_location (read_control_fixed_location),
        .read_control_base           (read_control_base),
        .read_control_length         (read_control_length),
        .read_control_go             (read_control_go),
        .read_control_done           (read_control_done),
        .read_data_available         (read_data_available),
        .read_buffer_data            (read_buffer_data),
        .read_acknowledge            (read_acknowledge),
        .sample_out                  (sample_out),
        .sample_valid                (sample_valid),
        .sample_ready                (sample_ready),
        .busy                        (busy),
        .done                        (done)
    );

    int checks = 0;
    int errors = 0;

    // FIFO model: main writes mem/wr_ptr, the pop process owns rd_ptr.
    logic [31:0] mem [256];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;
    int          ack_cnt = 0;
    int          ack_underflow = 0;

    // Monitor state.
    logic [15:0] got [$];
    logic [15:0] exp_q [$];
    int          done_cnt = 0;
    int          done_at_size = 0;
    logic        pend = 1'b0;
    logic [15:0] pend_val = '0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: never

    typedef struct {
        int          ready_mode;
        bit          early;
        logic [31:0] first_word;   // 0 selects random words
        logic [31:0] base_before;
        logic [31:0] base_after;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    // Pop on the edge that ends an ack cycle.
    always @(posedge rx_clk_out) begin
        if (read_acknowledge) begin
            ack_cnt <= ack_cnt + 1;
            if (rd_ptr == wr_ptr) ack_underflow <= ack_underflow + 1;
            else                  rd_ptr <= rd_ptr + 8'd1;
        end
    end

    // Show-ahead outputs refresh away from the active edge.
    always @(negedge rx_clk_out) begin
        read_data_available = (rd_ptr != wr_ptr);
        read_buffer_data    = mem[rd_ptr];
    end

    // Drive ready for the next edge, then log what that edge will accept.
    always @(negedge rx_clk_out) begin
        case (ready_mode)
            0:       sample_ready = 1'b1;
            1:       sample_ready = 1'($urandom_range(0, 1));
            default: sample_ready = 1'b0;
        endcase
        if (!reset_n) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                checks++;
                if (!(sample_valid && sample_out == pend_val)) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%0b data=%0h required valid=1 data=%0h",
                             sample_valid, sample_out, pend_val);
                end
            end
            if (sample_valid && sample_ready && !abort) got.push_back(sample_out);
            pend     <= sample_valid && !sample_ready && !abort;
            pend_val <= sample_out;
        end
        if (done) begin
            done_cnt     <= done_cnt + 1;
            done_at_size <= got.size();
        end
    end

    task automatic run_transfer(input vec_t v);
        int          g0;
        int          e0;
        int          a0;
        int          d0;
        int          cyc;
        bit          sent;
        logic [31:0] w;
        g0 = got.size();
        e0 = exp_q.size();
        a0 = ack_cnt;
        d0 = done_cnt;
        ready_mode = v.ready_mode;
        chk("base_before", read_control_base, v.base_before);
        chk("idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < WORDS; i++) begin
            w = (v.first_word != 0) ? v.first_word + 32'(i) : $urandom;
            push_word(w);
            exp_q.push_back(w[31:16]);
            exp_q.push_back(w[15:0]);
        end
        start = 1'b1;
        @(posedge rx_clk_out); #1;
        start = 1'b0;
        chk("go_pulse", 32'(read_control_go), 32'd1);
        chk("go_busy", 32'(busy), 32'd1);
        @(posedge rx_clk_out); #1;
        chk("go_single", 32'(read_control_go), 32'd0);
        cyc  = 0;
        sent = 1'b0;
        while (done_cnt == d0 && cyc < 2000) begin
            read_control_done = 1'b0;
            if (!sent && ((v.early && cyc == 2) || (!v.early && ack_cnt - a0 == WORDS))) begin
                read_control_done = 1'b1;
                sent = 1'b1;
            end
            @(posedge rx_clk_out); #1;
            cyc++;
        end
        read_control_done = 1'b0;
        chk("done_timeout", 32'(done_cnt > d0), 32'd1);
        repeat (4) @(posedge rx_clk_out);
        #1;
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("done_after_last", 32'(done_at_size - g0), 32'(2 * WORDS));
        chk("acks", 32'(ack_cnt - a0), 32'(WORDS));
        chk("n_samples", 32'(got.size() - g0), 32'(2 * WORDS));
        for (int i = 0; i < 2 * WORDS; i++) begin
            if (g0 + i < got.size()) chk("sample", 32'(got[g0 + i]), 32'(exp_q[e0 + i]));
        end
        chk("base_after", read_control_base, v.base_after);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int          g0;
        int          a0;
        int          d0;
        int          cyc;
        logic [31:0] base0;
        logic [31:0] w;
        vec_t        rv;

        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        read_control_done = 1'b0;
        ready_mode = 0;
        repeat (3) @(posedge rx_clk_out);
        #1;
        chk("rst_go", 32'(read_control_go), 32'd0);
        chk("rst_ack", 32'(read_acknowledge), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_base", read_control_base, 32'h0);
        chk("rst_length", read_control_length, 32'd64);
        chk("rst_fixed", 32'(read_control_fixed_location), 32'd0);
        reset_n = 1'b1;
        @(posedge rx_clk_out); #1;

        // Sequential transfers; base wraps at 0x80.
        vecs[0] = '{0, 1'b0, 32'hAAAA0001, 32'h00, 32'h40};
        vecs[1] = '{1, 1'b0, 32'h0,        32'h40, 32'h00};
        vecs[2] = '{1, 1'b1, 32'h0,        32'h00, 32'h40};
        vecs[3] = '{0, 1'b1, 32'h5555F000, 32'h40, 32'h00};
        for (int i = 0; i < 4; i++) run_transfer(vecs[i]);

        // Abort after three words, with five more arriving.
        ready_mode = 0;
        g0    = got.size();
        a0    = ack_cnt;
        d0    = done_cnt;
        base0 = read_control_base;
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            push_word(w);
            exp_q.push_back(w[31:16]);
            exp_q.push_back(w[15:0]);
        end
        start = 1'b1;
        @(posedge rx_clk_out); #1;
        start = 1'b0;
        cyc = 0;
        while (got.size() - g0 < 6 && cyc < 500) begin
            @(posedge rx_clk_out); #1;
            cyc++;
        end
        chk("abort_prefix_timeout", 32'(got.size() - g0), 32'd6);
        for (int i = 0; i < 5; i++) push_word($urandom);
        abort = 1'b1;
        @(posedge rx_clk_out); #1;
        abort = 1'b0;
        chk("abort_valid", 32'(sample_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge rx_clk_out);
        #1;
        read_control_done = 1'b1;
        @(posedge rx_clk_out); #1;
        read_control_done = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge rx_clk_out); #1;
            cyc++;
        end
        chk("abort_idle", 32'(busy), 32'd0);
        repeat (3) @(posedge rx_clk_out);
        #1;
        chk("abort_acks", 32'(ack_cnt - a0), 32'd8);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_base", read_control_base, base0);
        chk("abort_samples", 32'(got.size() - g0), 32'd6);
        chk("abort_fifo_empty", 32'(wr_ptr - rd_ptr), 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (g0 + i < got.size()) chk("abort_sample", 32'(got[g0 + i]), 32'(exp_q[exp_q.size() - 6 + i]));
        end

        // Reset while presenting the first half of a word.
        ready_mode = 2;
        push_word(32'hDEADBEEF);
        start = 1'b1;
        @(posedge rx_clk_out); #1;
        start = 1'b0;
        cyc = 0;
        while (!sample_valid && cyc < 100) begin
            @(posedge rx_clk_out); #1;
            cyc++;
        end
        chk("hi_reached", 32'(sample_valid), 32'd1);
        chk("hi_data", 32'(sample_out), 32'hDEAD);
        @(posedge rx_clk_out); #1;
        reset_n = 1'b0;
        #1;
        chk("arst_go", 32'(read_control_go), 32'd0);
        chk("arst_ack", 32'(read_acknowledge), 32'd0);
        chk("arst_valid", 32'(sample_valid), 32'd0);
        chk("arst_data", 32'(sample_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_base", read_control_base, 32'h0);
        repeat (2) @(posedge rx_clk_out);
        #1;
        reset_n = 1'b1;
        @(posedge rx_clk_out); #1;
        rv = '{0, 1'b0, 32'h12340001, 32'h00, 32'h40};
        run_transfer(rv);

        chk("ack_underflow", 32'(ack_underflow), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
